// File: rtl/intdiv_iterdiv_pkg.sv
// rtl/intdiv_iterdiv_pkg.sv - shared types and constants for the iterative signed divider
package intdiv_iterdiv_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed-digit (sd2) quotient digit codes as stored in the digit register
    localparam logic DIGIT_NEG1 = 1'b0;
    localparam logic DIGIT_POS1 = 1'b1;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Value of a two's-complement sign bit
    localparam logic POSITIVE = 1'b0;
    localparam logic NEGATIVE = 1'b1;

    // Width of the RUN step counter; at least one bit even for a single step
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/intdiv_nrstep.sv
// rtl/intdiv_nrstep.sv - one combinational non-restoring division step
//
// Ports:
//   rem_in  [N:0]   partial remainder before the step
//   bit_in          next dividend bit shifted into the remainder LSB
//   y       [N-1:0] divisor, signed
//   rem_out [N:0]   partial remainder after the add/subtract
//   digit           sd2 digit: DIGIT_POS1 when the new sign matches sign(y)
module intdiv_nrstep
    import intdiv_iterdiv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] y,
    output logic [N:0]   rem_out,
    output logic         digit
);

    logic [N:0] shifted;
    logic [N:0] ys;

    // The partial remainder stays inside [-|y|, |y|), so doubling it always
    // fits in N+1 bits and dropping the old MSB loses nothing.
    always_comb begin
        shifted = (rem_in << 1) | {{N{1'b0}}, bit_in};
        ys      = {y[N-1], y};
        if (shifted[N] != y[N-1]) begin
            rem_out = shifted + ys;
        end else begin
            rem_out = shifted - ys;
        end
        digit = (rem_out[N] == y[N-1]) ? DIGIT_POS1 : DIGIT_NEG1;
    end

endmodule

// File: rtl/intdiv_iterdiv.sv
// rtl/intdiv_iterdiv.sv - multi-cycle signed divider, DPC non-restoring digits per clock
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   in_x, in_y   [N-1:0]  dividend, divisor (signed)
//   out_valid/out_ready   result handshake, result held until accepted
//   out_z, out_r [N-1:0]  quotient (truncated toward zero), remainder (sign of dividend)
//   out_err               exception flag; live only when INTDIV_EXC_FLAG_EN is defined
module intdiv_iterdiv
    import intdiv_iterdiv_pkg::*;
#(
    parameter int N   = 8,
    parameter int DPC = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_z,
    output logic [N-1:0] out_r,
    output logic         out_err
);

    localparam int             STEPS    = N / DPC;
    localparam int             CW       = cnt_width(STEPS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEPS - 1);
    localparam logic [N-1:0]   MIN_VAL  = {NEGATIVE, {(N-1){1'b0}}};
    localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};

    if ((N % DPC) != 0 || N < 4) begin : g_param_check
        $error("intdiv_iterdiv: N must be >= 4 and a multiple of DPC");
    end

    state_t        state, state_next;
    logic [N:0]    rem;       // partial remainder
    logic [N-1:0]  dvd;       // dividend bits still to be shifted in
    logic [N-1:0]  quo;       // sd2 digits, first digit in the MSB
    logic [N-1:0]  div;
    logic          sign_x;
    logic          spc;       // current operation is a special case
    logic [CW-1:0] cnt;

    logic          accept;
    logic          special;
    logic [N-1:0]  z_fix, r_fix, q_base, dig_ext;
    logic [N:0]    ys;
    logic          corr;
    logic [DPC-1:0] digs;
    logic [N:0]    chain [DPC+1];

    assign accept  = in_valid & in_ready;
    assign special = (in_y == '0) || (in_x == MIN_VAL && in_y == '1);

    // Chain of DPC steps; step 0 consumes the dividend MSB and yields the
    // most significant digit of this cycle.
    assign chain[0] = rem;
    for (genvar j = 0; j < DPC; j++) begin : g_step
        intdiv_nrstep #(.N(N)) u_step (
            .rem_in  (chain[j]),
            .bit_in  (dvd[N-1-j]),
            .y       (div),
            .rem_out (chain[j+1]),
            .digit   (digs[DPC-1-j])
        );
    end

    always_comb begin
        dig_ext = '0;
        dig_ext[DPC-1:0] = digs;
    end

    // Quotient reconstruction: the digits recorded from the new remainder sign
    // are the operation choices of the following step, so the two's-complement
    // quotient is the first N-1 digits with a forced 1 appended. The last digit
    // (quo[0]) tells which way the final remainder must be pulled back.
    always_comb begin
        ys     = {div[N-1], div};
        q_base = {quo[N-1:1], 1'b1};
        corr   = ((rem != '0) && (rem[N] != sign_x)) || (rem == ys) || (rem == -ys);
        z_fix  = q_base;
        r_fix  = rem[N-1:0];
        if (spc) begin
            if (div == '0) begin
                z_fix = '1;
                r_fix = dvd;
            end else begin
                z_fix = MIN_VAL;
                r_fix = '0;
            end
        end else if (corr) begin
            if (quo[0] == DIGIT_POS1) begin
                z_fix = q_base + ONE_N;
                r_fix = rem[N-1:0] - div;
            end else begin
                z_fix = q_base - ONE_N;
                r_fix = rem[N-1:0] + div;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Special cases skip RUN and resolve in the single FIX cycle.
    always_comb begin
        state_next = state;
        in_ready   = OFF;
        out_valid  = OFF;
        case (state)
            IDLE: begin
                in_ready = ON;
                if (in_valid) begin
                    state_next = special ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = ON;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem    <= '0;
            dvd    <= '0;
            quo    <= '0;
            div    <= '0;
            sign_x <= POSITIVE;
            spc    <= 1'b0;
            cnt    <= '0;
            out_z  <= '0;
            out_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div    <= in_y;
                        dvd    <= in_x;
                        sign_x <= in_x[N-1];
                        rem    <= {(N+1){in_x[N-1]}};
                        quo    <= '0;
                        cnt    <= CNT_LAST;
                        spc    <= special;
                    end
                end
                RUN: begin
                    rem <= chain[DPC];
                    dvd <= dvd << DPC;
                    quo <= (quo << DPC) | dig_ext;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    out_z <= z_fix;
                    out_r <= r_fix;
                end
                default: ;
            endcase
        end
    end

`ifdef INTDIV_EXC_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (state == FIX) begin
            out_err <= spc;
        end else if (state == DONE && out_ready) begin
            out_err <= 1'b0;
        end
    end
`else
    assign out_err = OFF;
`endif

endmodule

// File: tb/tb_intdiv_iterdiv.sv
// tb/tb_intdiv_iterdiv.sv - scoreboard bench for intdiv_iterdiv over several N/DPC builds
module tb_intdiv_iterdiv;

`ifdef INTDIV_EXC_FLAG_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] iv, ordy;
    wire  [4:0] ir, ov, oe;
    logic [7:0] ix [5];
    logic [7:0] iy [5];
    wire  [7:0] oz [5];
    wire  [7:0] orm [5];
    wire  [3:0] z4 [2:4];
    wire  [3:0] r4 [2:4];

    typedef struct {
        int         dut;
        logic [7:0] z;
        logic [7:0] r;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    intdiv_iterdiv #(.N(8), .DPC(1)) u_n8d1 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_x(ix[0]), .in_y(iy[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_z(oz[0]), .out_r(orm[0]), .out_err(oe[0]));
    intdiv_iterdiv #(.N(8), .DPC(2)) u_n8d2 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_x(ix[1]), .in_y(iy[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_z(oz[1]), .out_r(orm[1]), .out_err(oe[1]));
    intdiv_iterdiv #(.N(4), .DPC(1)) u_n4d1 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_x(ix[2][3:0]), .in_y(iy[2][3:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_z(z4[2]), .out_r(r4[2]), .out_err(oe[2]));
    intdiv_iterdiv #(.N(4), .DPC(2)) u_n4d2 (
        .clock(clock), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_x(ix[3][3:0]), .in_y(iy[3][3:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .out_z(z4[3]), .out_r(r4[3]), .out_err(oe[3]));
    intdiv_iterdiv #(.N(4), .DPC(4)) u_n4d4 (
        .clock(clock), .reset(reset), .in_valid(iv[4]), .in_ready(ir[4]),
        .in_x(ix[4][3:0]), .in_y(iy[4][3:0]), .out_valid(ov[4]), .out_ready(ordy[4]),
        .out_z(z4[4]), .out_r(r4[4]), .out_err(oe[4]));

    for (genvar g = 2; g < 5; g++) begin : g_ext
        assign oz[g]  = {{4{z4[g][3]}}, z4[g]};
        assign orm[g] = {{4{r4[g][3]}}, r4[g]};
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 9;
            1:       return 5;
            2:       return 5;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: every result handshake pops one expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 5; k++) begin
                if (ov[k] && ordy[k]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected dut=%0d: result with empty scoreboard", k);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.dut != k || oz[k] != e.z || orm[k] != e.r || oe[k] != e.err) begin
                            bad++;
                            $display("FAIL result dut=%0d: got z=%0d r=%0d err=%0b, want dut=%0d z=%0d r=%0d err=%0b",
                                     k, $signed(oz[k]), $signed(orm[k]), oe[k],
                                     e.dut, $signed(e.z), $signed(e.r), e.err);
                        end
                    end
                end
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic issue(input int k, input int x, input int y);
        int n;
        n = 0;
        while (!ir[k] && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!ir[k]) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            iv[k] = 1'b1;
            ix[k] = 8'(x);
            iy[k] = 8'(y);
            @(posedge clock); #1;
            iv[k] = 1'b0;
        end
    endtask

    task automatic run(input int k, input int x, input int y, input int ez, input int er,
                       input bit eerr, input int elat);
        exp_t e;
        int   lat, n;
        e.dut = k;
        e.z   = 8'(ez);
        e.r   = 8'(er);
        e.err = eerr;
        sb.push_back(e);
        issue(k, x, y);
        lat = 0;
        while (!ov[k] && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk($sformatf("latency dut=%0d x=%0d y=%0d", k, x, y), lat, elat);
        n = 0;
        while (ov[k] && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (ov[k]) chk("out_valid_stuck", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        iv    = '0;
        ordy  = '1;
        for (int k = 0; k < 5; k++) begin
            ix[k] = '0;
            iy[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("reset dut=%0d", k),
                int'({ir[k], ov[k], oe[k], oz[k], orm[k]}), int'({1'b1, 1'b0, 1'b0, 16'h0000}));
        end
        reset = 1'b0;
        @(posedge clock); #1;

        run(0,    7,    3,    2,   1, 1'b0, 9);
        run(1, -120,   11,  -10, -10, 1'b0, 5);
        run(1,  120,  -11,  -10,  10, 1'b0, 5);
        run(0, -128,   -1, -128,   0, EXC,  1);
        run(0,    5,    0,   -1,   5, EXC,  1);
        run(0,   -7,    2,   -3,  -1, 1'b0, 9);
        run(0,  127, -128,    0, 127, 1'b0, 9);
        run(0, -128, -128,    1,   0, 1'b0, 9);
        run(0, -128,    3,  -42,  -2, 1'b0, 9);
        run(1, -128,   -1, -128,   0, EXC,  1);
        run(1,  100,    7,   14,   2, 1'b0, 5);
        run(1,   -6,    3,   -2,   0, 1'b0, 5);
        run(1,   -6,   -3,    2,   0, 1'b0, 5);

        // Backpressure: -50 / 7 -> z=-7, r=-1, held for 20 cycles
        e.dut = 0; e.z = 8'hF9; e.r = 8'hFF; e.err = 1'b0;
        sb.push_back(e);
        ordy[0] = 1'b0;
        issue(0, -50, 7);
        for (int n = 0; n < 100 && !ov[0]; n++) begin
            @(posedge clock); #1;
        end
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("bp_hold cycle %0d", c),
                int'({ov[0], ir[0], oe[0], oz[0], orm[0]}), int'({1'b1, 1'b0, 1'b0, 8'hF9, 8'hFF}));
            @(posedge clock); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clock); #1;
        chk("bp_release", int'({ov[0], ir[0]}), 1);

        // Reset in the middle of RUN discards the operation
        issue(0, 100, 7);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("reset_mid_run", int'({ov[0], ir[0], oz[0], orm[0]}), int'({1'b0, 1'b1, 16'h0000}));
        reset = 1'b0;
        @(posedge clock); #1;

        // Exhaustive N=4 sweep for DPC 1, 2, 4
        for (int k = 2; k < 5; k++) begin
            for (int x = -8; x < 8; x++) begin
                for (int y = -8; y < 8; y++) begin
                    if (y != 0) begin
                        logic [7:0] t;
                        bit         sp;
                        sp = (x == -8 && y == -1);
                        t  = 8'(x / y);
                        run(k, x, y, int'($signed({{4{t[3]}}, t[3:0]})), x % y,
                            EXC && sp, sp ? 1 : lat_of(k));
                    end
                end
            end
        end

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
